// File: rtl/seg_marquee.sv
// seg_marquee: scrolling-text driver for a bank of seven-segment digits.
//
// A small message buffer holds raw active-low gfedcba patterns (7'h7F = off).
// On every prescaled tick the frame index pos moves one step. Each frame places
// the message at a different offset in the display window, and the frame with
// pos=0 is always blank. dir selects which end of the window the text enters from.
//
// Optional build macro:
//   SEG_MARQUEE_HOLD_EN - adds a dwell stage. Once the window has filled
//                         (pos reaches NUM_DIGITS), the scroll holds for
//                         HOLD_TICKS extra ticks. Without the macro, HOLD_TICKS
//                         is ignored.
//
// Hold controller (only with SEG_MARQUEE_HOLD_EN):
//   state   | meaning
//   ST_RUN  | every tick advances pos
//   ST_HOLD | ticks count dwell, pos frozen until HOLD_TICKS reached

module seg_marquee #(
  parameter int NUM_DIGITS = 4,
  parameter int MSG_LEN    = 4,
  parameter int TICK_DIV   = 50_000_000,
  parameter int HOLD_TICKS = 0
) (
  input  logic                                                  ck,
  input  logic                                                  rs,
  input  logic                                                  en,
  input  logic                                                  dir,
  input  logic                                                  wr_en,
  input  logic [((MSG_LEN > 1) ? $clog2(MSG_LEN) : 1)-1:0]      wr_addr,
  input  logic [6:0]                                            wr_data,
  output logic [7*NUM_DIGITS-1:0]                               seg,
  output logic [((MSG_LEN + NUM_DIGITS > 1) ?
                 $clog2(MSG_LEN + NUM_DIGITS) : 1)-1:0]         pos,
  output logic                                                  wrap
);

  localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int PW = (MSG_LEN + NUM_DIGITS > 1) ? $clog2(MSG_LEN + NUM_DIGITS) : 1;
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int P  = MSG_LEN + NUM_DIGITS;

  logic [6:0]              buf_q [MSG_LEN];
  logic [CW-1:0]           cnt_q;
  logic [PW-1:0]           pos_q;
  logic                    wrap_q;
  logic [7*NUM_DIGITS-1:0] seg_q;
  logic [7*NUM_DIGITS-1:0] seg_next;
  logic                    tick;
  logic                    step;

  // a tick is the last cycle of each prescaler period, and only while running
  assign tick = en && (cnt_q == CW'(TICK_DIV - 1));

  // prescaler: counts 0..TICK_DIV-1 while enabled, frozen while paused
  always_ff @(posedge ck) begin
    if (rs) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + CW'(1);
    end
  end

`ifdef SEG_MARQUEE_HOLD_EN
  localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } hold_state_t;

  hold_state_t   state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;

  // hold controller state register
  always_ff @(posedge ck) begin
    if (rs) begin
      state_q    <= ST_RUN;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // hold controller: decides whether a tick steps pos or counts dwell
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    step       = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (tick) begin
          step = 1'b1;
          // the step into pos=NUM_DIGITS is the one that fills the window
          if ((HOLD_TICKS > 0) && (pos_q == PW'(NUM_DIGITS - 1))) begin
            state_d    = ST_HOLD;
            hold_cnt_d = '0;
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          hold_cnt_d = hold_cnt_q + HW'(1);
          if ((hold_cnt_q + HW'(1)) == HW'(HOLD_TICKS)) begin
            state_d = ST_RUN;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end
`else
  assign step = tick;
`endif

  // frame index and the registered wrap pulse
  always_ff @(posedge ck) begin
    if (rs) begin
      pos_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= step && (pos_q == PW'(P - 1));
      if (step) begin
        pos_q <= (pos_q == PW'(P - 1)) ? '0 : pos_q + PW'(1);
      end
    end
  end

  // message buffer; out-of-range addresses match no entry and are dropped
  always_ff @(posedge ck) begin
    if (rs) begin
      for (int m = 0; m < MSG_LEN; m++) begin
        buf_q[m] <= 7'h7F;
      end
    end else if (wr_en) begin
      for (int m = 0; m < MSG_LEN; m++) begin
        if (int'(wr_addr) == m) begin
          buf_q[m] <= wr_data;
        end
      end
    end
  end

  // frame mapping: digit d shows the character whose index lands on it this
  // frame; anything outside the message is blank
  always_comb begin
    seg_next = '1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      for (int m = 0; m < MSG_LEN; m++) begin
        if (dir ? ((int'(pos_q) - 1 - d) == m)
                : ((int'(pos_q) - NUM_DIGITS + d) == m)) begin
          seg_next[7*d +: 7] = buf_q[m];
        end
      end
    end
  end

  // output register: seg reflects the frame of the previous cycle
  always_ff @(posedge ck) begin
    if (rs) begin
      seg_q <= '1;
    end else begin
      seg_q <= seg_next;
    end
  end

  assign seg  = seg_q;
  assign pos  = pos_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_seg_marquee.sv
// Bench for seg_marquee: a frame-level model plus a per-cycle compare, and a
// second tiny instance (one digit, three characters, TICK_DIV=1) for
// out-of-range writes and single-cycle ticking. Honours SEG_MARQUEE_HOLD_EN.

module tb_seg_marquee;
  localparam int ND = 4;
  localparam int ML = 4;
  localparam int TD = 2;
  localparam int P  = ND + ML;
`ifdef SEG_MARQUEE_HOLD_EN
  localparam int HT       = 3;
  localparam int PASS_CYC = 22;
`else
  localparam int HT       = 0;
  localparam int PASS_CYC = 16;
`endif

  logic ck = 1'b0;
  always #5 ck = ~ck;

  logic        rs, en, dir, wr_en;
  logic [1:0]  wr_addr;
  logic [6:0]  wr_data;
  logic [27:0] seg;
  logic [2:0]  pos;
  logic        wrap;

  logic        rs2, en2, wr_en2;
  logic [1:0]  wr_addr2;
  logic [6:0]  wr_data2;
  logic [6:0]  seg2;
  logic [1:0]  pos2;
  logic        wrap2;

  seg_marquee #(.NUM_DIGITS(ND), .MSG_LEN(ML), .TICK_DIV(TD), .HOLD_TICKS(HT)) dut (
    .ck(ck), .rs(rs), .en(en), .dir(dir), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .seg(seg), .pos(pos), .wrap(wrap)
  );

  seg_marquee #(.NUM_DIGITS(1), .MSG_LEN(3), .TICK_DIV(1), .HOLD_TICKS(0)) dut2 (
    .ck(ck), .rs(rs2), .en(en2), .dir(1'b0), .wr_en(wr_en2), .wr_addr(wr_addr2),
    .wr_data(wr_data2), .seg(seg2), .pos(pos2), .wrap(wrap2)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- model ----------------
  logic [6:0]  m_buf [ML];
  int          m_pos, m_cnt, m_hcnt;
  bit          m_hold;
  logic [27:0] exp_seg;
  bit          exp_wrap;
  bit          check_en = 1'b0;

  function automatic logic [27:0] frame(input int p, input logic dr);
    logic [27:0] f;
    int k;
    f = '1;
    for (int d = 0; d < ND; d++) begin
      k = dr ? (p - 1 - d) : (p - 1 - (ND - 1 - d));
      if (k >= 0 && k < ML) f[7*d +: 7] = m_buf[k];
    end
    return f;
  endfunction

  initial begin
    forever begin
      @(posedge ck);
      cyc++;
      if (rs) begin
        for (int i = 0; i < ML; i++) m_buf[i] = 7'h7F;
        m_pos = 0; m_cnt = 0; m_hcnt = 0; m_hold = 1'b0;
        exp_seg = '1; exp_wrap = 1'b0;
        check_en = 1'b1;
      end else begin
        exp_seg  = frame(m_pos, dir);
        exp_wrap = 1'b0;
        if (wr_en && int'(wr_addr) < ML) m_buf[wr_addr] = wr_data;
        if (en) begin
          if (m_cnt == TD - 1) begin
            m_cnt = 0;
            if (!m_hold) begin
              if (m_pos == P - 1) begin
                m_pos = 0;
                exp_wrap = 1'b1;
              end else begin
                m_pos = m_pos + 1;
              end
              if (m_pos == ND && HT > 0) begin
                m_hold = 1'b1;
                m_hcnt = 0;
              end
            end else begin
              m_hcnt = m_hcnt + 1;
              if (m_hcnt == HT) m_hold = 1'b0;
            end
          end else begin
            m_cnt = m_cnt + 1;
          end
        end
      end
    end
  end

  // per-cycle compare against the model
  initial begin
    forever begin
      @(negedge ck);
      if (check_en) begin
        chk("model_seg", {4'h0, seg}, {4'h0, exp_seg});
        chk("model_pos", {29'h0, pos}, m_pos);
        chk("model_wrap", {31'h0, wrap}, {31'h0, exp_wrap});
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_mpos(input int p);
    int n;
    n = 0;
    while (m_pos != p && n < 200) begin
      @(negedge ck);
      n++;
    end
    chk("wait_pos_timeout", (n < 200) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_wrap(output int c);
    int n;
    n = 0;
    while (wrap !== 1'b1 && n < 60) begin
      @(negedge ck);
      n++;
    end
    chk("wait_wrap_timeout", (n < 60) ? 32'd1 : 32'd0, 32'd1);
    c = cyc;
  endtask

  // ---------------- directed stimulus ----------------
  logic [6:0] load_data [4];
  logic [6:0] exp2_seg  [5];
  logic [1:0] exp2_pos  [5];
  logic       exp2_wrap [5];
  int c1, c2;

  initial begin
    load_data = '{7'h08, 7'h42, 7'h0C, 7'h0E};
    exp2_seg  = '{7'h7F, 7'h01, 7'h02, 7'h03, 7'h7F};
    exp2_pos  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    exp2_wrap = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    rs = 1'b1; en = 1'b1; dir = 1'b0;
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 7'h08;
    rs2 = 1'b1; en2 = 1'b0; wr_en2 = 1'b0; wr_addr2 = 2'd0; wr_data2 = 7'h00;
    @(negedge ck);
    @(negedge ck);
    chk("reset_seg", {4'h0, seg}, 32'h0FFFFFFF);
    chk("reset_pos", {29'h0, pos}, 32'd0);
    chk("reset_wrap", {31'h0, wrap}, 32'd0);

    // small instance: load three chars, try out-of-range address 3
    rs2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_en2 = 1'b1; wr_addr2 = 2'(i); wr_data2 = (i < 3) ? 7'(i + 1) : 7'h00;
      @(negedge ck);
    end
    wr_en2 = 1'b0; en2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge ck);
      chk("small_seg", {25'h0, seg2}, {25'h0, exp2_seg[i]});
      chk("small_pos", {30'h0, pos2}, {30'h0, exp2_pos[i]});
      chk("small_wrap", {31'h0, wrap2}, {31'h0, exp2_wrap[i]});
    end
    en2 = 1'b0;

    // write issued during reset must have been discarded
    rs = 1'b0; wr_en = 1'b0; en = 1'b1;
    wait_mpos(1);
    @(negedge ck);
    chk("blank_after_rs_write", {4'h0, seg}, 32'h0FFFFFFF);

    rs = 1'b1; en = 1'b0;
    @(negedge ck);
    rs = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 2'(i); wr_data = load_data[i];
      @(negedge ck);
    end
    wr_en = 1'b0; en = 1'b1;

    wait_mpos(1);
    @(negedge ck);
    chk("dir0_pos1", {4'h0, seg}, {4'h0, 7'h08, 7'h7F, 7'h7F, 7'h7F});
    wait_mpos(4);
    @(negedge ck);
    chk("dir0_pos4", {4'h0, seg}, {4'h0, 7'h0E, 7'h0C, 7'h42, 7'h08});
    wait_mpos(7);
    @(negedge ck);
    chk("dir0_pos7", {4'h0, seg}, {4'h0, 7'h7F, 7'h7F, 7'h7F, 7'h0E});

    wait_wrap(c1);
    @(negedge ck);
    chk("wrap_one_cycle", {31'h0, wrap}, 32'd0);
    wait_wrap(c2);
    chk("wrap_period", c2 - c1, PASS_CYC);

    dir = 1'b1;
    wait_mpos(1);
    @(negedge ck);
    chk("dir1_pos1", {4'h0, seg}, {4'h0, 7'h7F, 7'h7F, 7'h7F, 7'h08});
    wait_mpos(4);
    @(negedge ck);
    chk("dir1_pos4", {4'h0, seg}, {4'h0, 7'h08, 7'h42, 7'h0C, 7'h0E});

    wait_mpos(3);
    dir = 1'b0;
    @(negedge ck);
    chk("dir_toggle_pos", {29'h0, pos}, 32'd3);
    chk("dir_toggle_seg", {4'h0, seg}, {4'h0, 7'h0C, 7'h42, 7'h08, 7'h7F});

    // pause in the second cycle of pos=5, so one prescaler count remains
    wait_mpos(5);
    @(negedge ck);
    en = 1'b0;
    repeat (10) @(negedge ck);
    chk("pause_pos", {29'h0, pos}, 32'd5);
    chk("pause_seg", {4'h0, seg}, {4'h0, 7'h7F, 7'h0E, 7'h0C, 7'h42});
    chk("pause_wrap", {31'h0, wrap}, 32'd0);
    en = 1'b1;
    @(negedge ck);
    chk("resume_pos", {29'h0, pos}, 32'd6);

    wait_mpos(4);
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 7'h7F;
    @(negedge ck);
    wr_en = 1'b0;
    chk("write_latency_t1", {4'h0, seg}, {4'h0, 7'h0E, 7'h0C, 7'h42, 7'h08});
    @(negedge ck);
    chk("write_latency_t2", {4'h0, seg}, {4'h0, 7'h0E, 7'h0C, 7'h7F, 7'h08});

    repeat (20) @(negedge ck);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
